// File: rtl/alsu_arbiter_ctrl.sv
// ----------------------------------------------------------------------------
// alsu_arbiter_ctrl
//
// Lets two command requesters share one ALSU. An accepted command is
// registered onto the ALSU input ports. The controller waits out the ALSU
// pipeline latency, captures alsu_out, and returns it on a valid/ready
// response channel. Commands that the ALSU cannot execute meaningfully can be
// rejected locally (CHECK_INVALID=1). A rejected command never reaches the
// ALSU and is answered on the next cycle with rsp_err=1.
//
// Parameters
//   ALSU_LAT       cycles from the registered ALSU inputs to a valid alsu_out
//                  (1..15)
//   CHECK_INVALID  1 = reject invalid commands locally, 0 = forward everything
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   r0_valid/r0_ready/r0_cmd      requester 0 command channel
//   r1_valid/r1_ready/r1_cmd      requester 1 command channel
//                                 cmd layout: [15:13] opcode, [12:10] A,
//                                 [9:7] B, [6] cin, [5] serial_in,
//                                 [4] red_op_A, [3] red_op_B, [2] bypass_A,
//                                 [1] bypass_B, [0] direction
//   rsp_valid/rsp_ready           response handshake
//   rsp_id, rsp_data, rsp_err     response payload
//   busy                          high whenever the controller is not IDLE
//   op_count                      completed responses (wraps at 256)
//   alsu_*                        registered ALSU input ports
//   alsu_out                      ALSU result
// ----------------------------------------------------------------------------
module alsu_arbiter_ctrl #(
    parameter int ALSU_LAT      = 2,
    parameter bit CHECK_INVALID = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [15:0] r0_cmd,

    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [15:0] r1_cmd,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [5:0]  rsp_data,
    output logic        rsp_err,

    output logic        busy,
    output logic [7:0]  op_count,

    output logic [2:0]  alsu_A,
    output logic [2:0]  alsu_B,
    output logic [2:0]  alsu_opcode,
    output logic        alsu_cin,
    output logic        alsu_serial_in,
    output logic        alsu_red_op_A,
    output logic        alsu_red_op_B,
    output logic        alsu_bypass_A,
    output logic        alsu_bypass_B,
    output logic        alsu_direction,
    input  logic [5:0]  alsu_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // The counter is loaded at accept time. ISSUE and WAIT then count it
    // down. The result is sampled in whichever of the two states sees zero.
    // This gives rsp_valid in cycle T+1+ALSU_LAT for every legal latency,
    // including ALSU_LAT=1, where ISSUE goes straight to RESP.
    localparam logic [3:0] LAT_LOAD = 4'(ALSU_LAT - 1);

    state_t      state_reg;
    state_t      state_next;

    logic        rr_ptr_reg;       // requester favoured on contention
    logic [3:0]  cnt_reg;
    logic [15:0] alsu_cmd_reg;     // command currently presented to the ALSU
    logic        rsp_id_reg;
    logic [5:0]  rsp_data_reg;
    logic        rsp_err_reg;
    logic [7:0]  op_count_reg;

    logic        grant0;
    logic        grant1;
    logic        accept;
    logic        sel_id;
    logic [15:0] sel_cmd;
    logic [2:0]  sel_op;
    logic        bad_opcode;
    logic        bad_reduction;
    logic        cmd_invalid;
    logic        cnt_zero;
    logic        rsp_fire;
    logic        in_flight;

    // ------------------------------------------------------------------
    // Round-robin grant. Grants are only raised in IDLE. A lone valid
    // always wins. On contention the favoured requester wins.
    // ------------------------------------------------------------------
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_reg == IDLE) begin
            grant0 = r0_valid && (!r1_valid || !rr_ptr_reg);
            grant1 = r1_valid && (!r0_valid ||  rr_ptr_reg);
        end
    end

    assign r0_ready = grant0;
    assign r1_ready = grant1;
    assign accept   = grant0 | grant1;
    assign sel_id   = grant1;
    assign sel_cmd  = grant1 ? r1_cmd : r0_cmd;
    assign sel_op   = sel_cmd[15:13];

    // Opcodes 110/111 are undefined. Reduction modes only make sense for
    // the bitwise opcodes 000 (AND) and 001 (XOR).
    assign bad_opcode    = (sel_op == 3'b110) || (sel_op == 3'b111);
    assign bad_reduction = (sel_cmd[4] || sel_cmd[3]) && (sel_op[2:1] != 2'b00);
    assign cmd_invalid   = CHECK_INVALID && (bad_opcode || bad_reduction);

    assign cnt_zero  = (cnt_reg == 4'd0);
    assign rsp_fire  = (state_reg == RESP) && rsp_ready;
    assign in_flight = (state_reg == ISSUE) || (state_reg == WAIT);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = cmd_invalid ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                state_next = cnt_zero ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt_zero) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: command capture, latency counter, response payload
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg   <= 1'b0;
            cnt_reg      <= 4'd0;
            alsu_cmd_reg <= 16'd0;
            rsp_id_reg   <= 1'b0;
            rsp_data_reg <= 6'd0;
            rsp_err_reg  <= 1'b0;
            op_count_reg <= 8'd0;
        end else begin
            if (accept) begin
                rr_ptr_reg   <= ~sel_id;
                rsp_id_reg   <= sel_id;
                rsp_err_reg  <= cmd_invalid;
                rsp_data_reg <= 6'd0;
                cnt_reg      <= LAT_LOAD;
                // A rejected command leaves the ALSU ports untouched.
                if (!cmd_invalid) begin
                    alsu_cmd_reg <= sel_cmd;
                end
            end

            if (in_flight) begin
                if (cnt_zero) begin
                    rsp_data_reg <= alsu_out;
                end else begin
                    cnt_reg <= cnt_reg - 4'd1;
                end
            end

            if (rsp_fire) begin
                op_count_reg <= op_count_reg + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign rsp_valid      = (state_reg == RESP);
    assign rsp_id         = rsp_id_reg;
    assign rsp_data       = rsp_data_reg;
    assign rsp_err        = rsp_err_reg;
    assign busy           = (state_reg != IDLE);
    assign op_count       = op_count_reg;

    assign alsu_opcode    = alsu_cmd_reg[15:13];
    assign alsu_A         = alsu_cmd_reg[12:10];
    assign alsu_B         = alsu_cmd_reg[9:7];
    assign alsu_cin       = alsu_cmd_reg[6];
    assign alsu_serial_in = alsu_cmd_reg[5];
    assign alsu_red_op_A  = alsu_cmd_reg[4];
    assign alsu_red_op_B  = alsu_cmd_reg[3];
    assign alsu_bypass_A  = alsu_cmd_reg[2];
    assign alsu_bypass_B  = alsu_cmd_reg[1];
    assign alsu_direction = alsu_cmd_reg[0];

endmodule

// File: tb/tb_alsu_arbiter_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alsu_arbiter_ctrl
//
// Three controller instances share one clock and one reset:
//   0: defaults (ALSU_LAT=2, CHECK_INVALID=1)
//   1: CHECK_INVALID=0
//   2: ALSU_LAT=4
// Each instance has its own behavioural ALSU. That ALSU computes a simple
// function of its inputs and delays the result by ALSU_LAT-1 registers, so
// alsu_out is valid ALSU_LAT edges after the inputs are registered.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alsu_arbiter_ctrl;

    logic clk;
    logic rst;

    logic        r0_valid [3];
    logic        r0_ready [3];
    logic [15:0] r0_cmd   [3];
    logic        r1_valid [3];
    logic        r1_ready [3];
    logic [15:0] r1_cmd   [3];
    logic        rsp_valid[3];
    logic        rsp_ready[3];
    logic        rsp_id   [3];
    logic [5:0]  rsp_data [3];
    logic        rsp_err  [3];
    logic        busy     [3];
    logic [7:0]  op_count [3];
    logic [2:0]  alsu_A   [3];
    logic [2:0]  alsu_B   [3];
    logic [2:0]  alsu_op  [3];
    logic        alsu_cin [3];
    logic        alsu_sin [3];
    logic        alsu_rA  [3];
    logic        alsu_rB  [3];
    logic        alsu_bA  [3];
    logic        alsu_bB  [3];
    logic        alsu_dir [3];
    logic [5:0]  alsu_out [3];

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_cnt [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALSU: 000 A&B, 001 A^B, 010 A+B+cin, otherwise {opcode,A}
    function automatic logic [5:0] alsu_fn(input logic [2:0] op, input logic [2:0] a,
                                           input logic [2:0] b, input logic cin);
        case (op)
            3'b000:  return {3'b000, a & b};
            3'b001:  return {3'b000, a ^ b};
            3'b010:  return 6'(a) + 6'(b) + 6'(cin);
            default: return {op, a};
        endcase
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int LAT_G = (gi == 2) ? 4 : 2;
        localparam bit CHK_G = (gi == 1) ? 1'b0 : 1'b1;

        logic [5:0] pipe [1:LAT_G-1];

        always @(posedge clk) begin
            pipe[1] <= alsu_fn(alsu_op[gi], alsu_A[gi], alsu_B[gi], alsu_cin[gi]);
            for (int k = 2; k < LAT_G; k++) pipe[k] <= pipe[k-1];
        end
        assign alsu_out[gi] = pipe[LAT_G-1];

        alsu_arbiter_ctrl #(.ALSU_LAT(LAT_G), .CHECK_INVALID(CHK_G)) dut (
            .clk            (clk),
            .rst            (rst),
            .r0_valid       (r0_valid[gi]),
            .r0_ready       (r0_ready[gi]),
            .r0_cmd         (r0_cmd[gi]),
            .r1_valid       (r1_valid[gi]),
            .r1_ready       (r1_ready[gi]),
            .r1_cmd         (r1_cmd[gi]),
            .rsp_valid      (rsp_valid[gi]),
            .rsp_ready      (rsp_ready[gi]),
            .rsp_id         (rsp_id[gi]),
            .rsp_data       (rsp_data[gi]),
            .rsp_err        (rsp_err[gi]),
            .busy           (busy[gi]),
            .op_count       (op_count[gi]),
            .alsu_A         (alsu_A[gi]),
            .alsu_B         (alsu_B[gi]),
            .alsu_opcode    (alsu_op[gi]),
            .alsu_cin       (alsu_cin[gi]),
            .alsu_serial_in (alsu_sin[gi]),
            .alsu_red_op_A  (alsu_rA[gi]),
            .alsu_red_op_B  (alsu_rB[gi]),
            .alsu_bypass_A  (alsu_bA[gi]),
            .alsu_bypass_B  (alsu_bB[gi]),
            .alsu_direction (alsu_dir[gi]),
            .alsu_out       (alsu_out[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] a,
                                       input logic [2:0] b, input logic cin, input logic red_a);
        return {op, a, b, cin, 1'b0, red_a, 4'b0000};
    endfunction

    // One transaction on instance k. eid is the requester expected to win.
    // eop/ea are the expected ALSU opcode/A after the accept. bp is the number
    // of extra cycles rsp_ready is held low. hold keeps the valids asserted
    // after the accept, for back-to-back contention.
    task automatic txn(input int k, input logic v0, input logic v1,
                       input logic [15:0] c0, input logic [15:0] c1,
                       input logic eid, input logic eerr, input logic [5:0] edata,
                       input int elat, input logic [2:0] eop, input logic [2:0] ea,
                       input int bp, input logic hold);
        int n;
        rsp_ready[k] = (bp == 0);
        r0_valid[k] = v0; r1_valid[k] = v1;
        r0_cmd[k] = c0;   r1_cmd[k] = c1;
        #1;
        check("ready_win",  eid ? r1_ready[k] : r0_ready[k], 1);
        check("ready_lose", eid ? r0_ready[k] : r1_ready[k], 0);
        tick;
        if (!hold) begin r0_valid[k] = 1'b0; r1_valid[k] = 1'b0; end
        check("alsu_opcode", alsu_op[k], eop);
        check("alsu_A", alsu_A[k], ea);
        check("busy_after_accept", busy[k], 1);
        n = 1;
        while (!rsp_valid[k] && n < 40) begin tick; n++; end
        check("latency", n, elat);
        check("rsp_id", rsp_id[k], eid);
        check("rsp_err", rsp_err[k], eerr);
        check("rsp_data", rsp_data[k], edata);
        check("no_ready_resp", r0_ready[k] | r1_ready[k], 0);
        for (int i = 0; i < bp; i++) begin
            r0_valid[k] = 1'b1; r1_valid[k] = 1'b1;
            tick;
            check("bp_valid", rsp_valid[k], 1);
            check("bp_data", rsp_data[k], edata);
            check("bp_id", rsp_id[k], eid);
            check("bp_err", rsp_err[k], eerr);
            check("bp_ready", r0_ready[k] | r1_ready[k], 0);
            check("bp_busy", busy[k], 1);
        end
        if (bp > 0) begin
            r0_valid[k] = hold ? v0 : 1'b0;
            r1_valid[k] = hold ? v1 : 1'b0;
        end
        rsp_ready[k] = 1'b1;
        tick;
        exp_cnt[k] = exp_cnt[k] + 8'd1;
        check("rsp_valid_low", rsp_valid[k], 0);
        check("busy_idle", busy[k], 0);
        check("op_count", op_count[k], exp_cnt[k]);
        $display("txn inst=%0d id=%0d err=%0d data=%0d lat=%0d op_count=%0d",
                 k, rsp_id[k], rsp_err[k], rsp_data[k], n, op_count[k]);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            r0_valid[k] = 1'b0; r1_valid[k] = 1'b0;
            r0_cmd[k] = 16'd0;  r1_cmd[k] = 16'd0;
            rsp_ready[k] = 1'b1;
            exp_cnt[k] = 8'd0;
        end
        tick;
        tick;
        for (int k = 0; k < 3; k++) begin
            check("rst_rsp_valid", rsp_valid[k], 0);
            check("rst_busy", busy[k], 0);
            check("rst_op_count", op_count[k], 0);
            check("rst_alsu_op", alsu_op[k], 0);
            check("rst_rsp_data", rsp_data[k], 0);
        end
        rst = 1'b0;
        tick;

        // Instance 0: single command, invalid screening, backpressure
        txn(0, 1, 0, mk(3'd2, 3'd3, 3'd2, 1'b1, 1'b0), 16'd0, 0, 0, 6'd6, 3, 3'd2, 3'd3, 0, 0);
        check("alsu_B", alsu_B[0], 2);
        check("alsu_cin", alsu_cin[0], 1);
        txn(0, 0, 1, 16'd0, mk(3'd6, 3'd4, 3'd1, 1'b0, 1'b0), 1, 1, 6'd0, 1, 3'd2, 3'd3, 0, 0);
        txn(0, 1, 0, mk(3'd2, 3'd1, 3'd1, 1'b0, 1'b1), 16'd0, 0, 1, 6'd0, 1, 3'd2, 3'd3, 0, 0);
        txn(0, 1, 0, mk(3'd1, 3'd5, 3'd3, 1'b0, 1'b0), 16'd0, 0, 0, 6'd6, 3, 3'd1, 3'd5, 5, 0);

        // Reset asserted while instance 0 is in WAIT
        r0_valid[0] = 1'b1; r0_cmd[0] = mk(3'd2, 3'd3, 3'd2, 1'b1, 1'b0);
        #1;
        tick;
        r0_valid[0] = 1'b0;
        tick;
        #2 rst = 1'b1;
        #1;
        check("rstw_rsp_valid", rsp_valid[0], 0);
        check("rstw_busy", busy[0], 0);
        check("rstw_alsu_op", alsu_op[0], 0);
        check("rstw_alsu_A", alsu_A[0], 0);
        check("rstw_op_count", op_count[0], 0);
        for (int k = 0; k < 3; k++) exp_cnt[k] = 8'd0;
        tick;
        rst = 1'b0;
        tick;

        // Contention: grants alternate starting with r0
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                txn(0, 1, 1, mk(3'd0, 3'd6, 3'd3, 1'b0, 1'b0), mk(3'd2, 3'd1, 3'd2, 1'b0, 1'b0),
                    0, 0, 6'd2, 3, 3'd0, 3'd6, 0, (i != 3));
            else
                txn(0, 1, 1, mk(3'd0, 3'd6, 3'd3, 1'b0, 1'b0), mk(3'd2, 3'd1, 3'd2, 1'b0, 1'b0),
                    1, 0, 6'd3, 3, 3'd2, 3'd1, 0, (i != 3));
        end

        // 252 more completions bring the total since reset to 256
        for (int i = 0; i < 252; i++)
            txn(0, 1, 0, mk(3'd2, 3'd3, 3'd2, 1'b1, 1'b0), 16'd0, 0, 0, 6'd6, 3, 3'd2, 3'd3, 0, 0);
        check("op_count_wrap", op_count[0], 0);

        // Instance 1: no local screening, so both commands are forwarded
        txn(1, 0, 1, 16'd0, mk(3'd6, 3'd5, 3'd0, 1'b0, 1'b0), 1, 0, 6'd53, 3, 3'd6, 3'd5, 0, 0);
        txn(1, 1, 0, mk(3'd2, 3'd1, 3'd1, 1'b0, 1'b1), 16'd0, 0, 0, 6'd2, 3, 3'd2, 3'd1, 0, 0);
        check("nochk_red_op_A", alsu_rA[1], 1);

        // Instance 2: ALSU_LAT=4, so the response arrives in T+5
        txn(2, 1, 0, mk(3'd2, 3'd7, 3'd7, 1'b1, 1'b0), 16'd0, 0, 0, 6'd15, 5, 3'd2, 3'd7, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
